// File: rtl/console_printer.sv
// Converts a binary value into an ASCII character stream for the VGA text console,
// one character slot per clock, in uppercase hex or zero-suppressed decimal.
module console_printer #(
  parameter int VALUE_W    = 32,
  parameter int HEX_DIGITS = VALUE_W / 4,
  parameter int DEC_DIGITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear_req,
  input  logic [VALUE_W-1:0] value,
  input  logic               dec_mode,
  input  logic [7:0]         term_char,
  output logic [7:0]         append_char,
  output logic               clear,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE and
  // clear_req is low; clear_req is accepted on every edge and always wins.

  localparam int BCD_W  = 4 * DEC_DIGITS;
  localparam int MAXC   = (VALUE_W > DEC_DIGITS) ? VALUE_W : DEC_DIGITS;
  localparam int CNT_W  = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(VALUE_W - 1);
  localparam logic [CNT_W-1:0] HEX_LAST  = CNT_W'(HEX_DIGITS - 1);
  localparam logic [CNT_W-1:0] DEC_LAST  = CNT_W'(DEC_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_EMIT    = 3'd2,
    S_TERM    = 3'd3,
    S_CLR     = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [VALUE_W-1:0] sh;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt;
  logic               dec_r;
  logic [7:0]         term_r;
  logic               seen_nz;
  logic               fin_r;

  logic [3:0]         digit;
  logic [7:0]         digit_ascii;
  logic [CNT_W-1:0]   last_slot;
  logic               suppress;

  logic [7:0]         append_nx;
  logic               clear_nx;
  logic               busy_nx;
  logic               done_nx;
  logic               fin_nx;

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DEC_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj   = dd_adjust(bcd);
  assign dbg_state = state;

  // Both digit sources are shifted left one nibble per slot, so the MSB nibble is current.
  assign digit       = dec_r ? bcd[BCD_W-1 -: 4] : sh[VALUE_W-1 -: 4];
  assign digit_ascii = (digit < 4'd10) ? {4'h3, digit} : (8'h37 + {4'h0, digit});
  assign last_slot   = dec_r ? DEC_LAST : HEX_LAST;
  assign suppress    = (digit == 4'd0) && !seen_nz && (cnt != last_slot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_req) begin
      state_nx = S_CLR;
    end else begin
      case (state)
        S_IDLE:    if (start) state_nx = dec_mode ? S_CONVERT : S_EMIT;
        S_CONVERT: if (cnt == CONV_LAST) state_nx = S_EMIT;
        S_EMIT:    if (cnt == last_slot) state_nx = S_TERM;
        S_TERM:    state_nx = S_IDLE;
        S_CLR:     state_nx = S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    append_nx = 8'h00;
    clear_nx  = 1'b0;
    fin_nx    = 1'b0;
    busy_nx   = (state_nx != S_IDLE) || (state == S_TERM);
    done_nx   = fin_r && !clear_req;
    if (state_nx == S_CLR) begin
      clear_nx = 1'b1;
    end else begin
      case (state)
        S_EMIT:  append_nx = suppress ? 8'h00 : digit_ascii;
        S_TERM: begin
          append_nx = term_r;
          fin_nx    = 1'b1;
        end
        default: append_nx = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      append_char <= 8'h00;
      clear       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fin_r       <= 1'b0;
    end else begin
      append_char <= append_nx;
      clear       <= clear_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      fin_r       <= fin_nx;
    end
  end

  // Capture on an accepted start, double-dabble in CONVERT, nibble shifting in EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      bcd     <= '0;
      cnt     <= '0;
      dec_r   <= 1'b0;
      term_r  <= 8'h00;
      seen_nz <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !clear_req) begin
            sh      <= value;
            dec_r   <= dec_mode;
            term_r  <= term_char;
            bcd     <= '0;
            cnt     <= '0;
            seen_nz <= 1'b0;
          end
        end
        S_CONVERT: begin
          bcd <= {bcd_adj[BCD_W-2:0], sh[VALUE_W-1]};
          sh  <= sh << 1;
          cnt <= (cnt == CONV_LAST) ? '0 : cnt + CNT_W'(1);
        end
        S_EMIT: begin
          cnt     <= cnt + CNT_W'(1);
          sh      <= sh << 4;
          bcd     <= bcd << 4;
          seen_nz <= seen_nz | (digit != 4'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_console_printer.sv
// Directed bench for console_printer: hex and decimal prints, zero suppression,
// ignored starts, clear aborts and asynchronous reset mid-print.
module tb_console_printer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clear_req;
  logic [31:0] value;
  logic        dec_mode;
  logic [7:0]  term_char;
  logic [7:0]  append_char;
  logic        clear;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int n_checks;
  int n_errors;
  logic [7:0] got [0:63];

  console_printer #(.VALUE_W(32), .HEX_DIGITS(8), .DEC_DIGITS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clear_req   (clear_req),
    .value       (value),
    .dec_mode    (dec_mode),
    .term_char   (term_char),
    .append_char (append_char),
    .clear       (clear),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference character for slot s: repeated division, independent of the BCD datapath.
  function automatic logic [7:0] exp_char(input logic [31:0] v, input logic d, input int s);
    longint unsigned radix, w, dig, vv;
    int n;
    logic [7:0] r;
    radix = d ? 64'd10 : 64'd16;
    n     = d ? 10 : 8;
    vv    = {32'd0, v};
    w     = 64'd1;
    for (int i = 0; i < n - 1 - s; i++) w = w * radix;
    dig = (vv / w) % radix;
    if (vv < w && s != n - 1) return 8'h00;
    r = (dig < 64'd10) ? (dig[7:0] + 8'h30) : (dig[7:0] + 8'h37);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full print with per-slot checks; a spurious start is driven before edge sk (0 = none).
  task automatic run_print(input logic [31:0] v, input logic d, input logic [7:0] t, input int sk);
    int n, first, last_k;
    n      = d ? 10 : 8;
    first  = d ? 33 : 1;
    last_k = first + n + 1;
    value = v; dec_mode = d; term_char = t; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_at_e0", busy, 1'b1);
    for (int k = 1; k <= last_k + 1; k++) begin
      if (k == sk) begin
        start = 1'b1; value = 32'h5555_5555; dec_mode = ~d; term_char = 8'h21;
      end
      tick();
      if (k == sk) begin
        start = 1'b0; value = v; dec_mode = d; term_char = t;
      end
      got[k] = append_char;
      if (k >= first && k < first + n)
        check($sformatf("slot_k%0d", k), append_char, exp_char(v, d, k - first));
      else if (k == first + n)
        check($sformatf("term_k%0d", k), append_char, t);
      else
        check($sformatf("quiet_k%0d", k), append_char, 8'h00);
      check($sformatf("done_k%0d", k), done, k == last_k);
      check($sformatf("busy_k%0d", k), busy, k < last_k);
      check($sformatf("clear_k%0d", k), clear, 1'b0);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; clear_req = 1'b0;
    value = '0; dec_mode = 1'b0; term_char = 8'h00;
    #1;
    check("rst_append", append_char, 8'h00);
    check("rst_clear", clear, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // hex DEADBEEF with space terminator
    run_print(32'hDEAD_BEEF, 1'b0, 8'h20, 0);
    check("hex_first_D", got[1], 8'h44);
    check("hex_last_F", got[8], 8'h46);
    check("hex_term", got[9], 8'h20);

    // decimal 1234, no terminator
    run_print(32'd1234, 1'b1, 8'h00, 0);
    check("dec_slot6_sup", got[38], 8'h00);
    check("dec_1", got[39], 8'h31);
    check("dec_4", got[42], 8'h34);
    check("dec_term_none", got[43], 8'h00);

    // decimal 0 and all-ones
    run_print(32'd0, 1'b1, 8'h00, 0);
    check("dec_zero_last", got[42], 8'h30);
    check("dec_zero_first", got[33], 8'h00);
    run_print(32'hFFFF_FFFF, 1'b1, 8'h0A, 0);
    check("dec_max_4", got[33], 8'h34);
    check("dec_max_5", got[42], 8'h35);
    check("dec_max_term", got[43], 8'h0A);

    // hex 0xA with a start pulse while busy
    run_print(32'h0000_000A, 1'b0, 8'h2C, 3);
    check("hex_a_sup", got[7], 8'h00);
    check("hex_a_digit", got[8], 8'h41);

    // clear at E0+4 of a hex print
    value = 32'hDEAD_BEEF; dec_mode = 1'b0; term_char = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) clear_req = 1'b1;
      tick();
      if (k == 4) clear_req = 1'b0;
      if (k == 1) check("clr_pre1", append_char, 8'h44);
      else if (k == 2) check("clr_pre2", append_char, 8'h45);
      else if (k == 3) check("clr_pre3", append_char, 8'h41);
      else check($sformatf("clr_quiet_k%0d", k), append_char, 8'h00);
      check($sformatf("clr_pulse_k%0d", k), clear, k == 4);
      check($sformatf("clr_busy_k%0d", k), busy, k <= 4);
      check($sformatf("clr_nodone_k%0d", k), done, 1'b0);
    end

    // start and clear together in idle
    value = 32'h1234_5678; dec_mode = 1'b0; term_char = 8'h20;
    start = 1'b1; clear_req = 1'b1;
    tick();
    start = 1'b0; clear_req = 1'b0;
    check("both_clear", clear, 1'b1);
    check("both_append", append_char, 8'h00);
    for (int k = 2; k <= 12; k++) begin
      tick();
      check($sformatf("both_quiet_k%0d", k), append_char, 8'h00);
      check($sformatf("both_clear_k%0d", k), clear, 1'b0);
      check($sformatf("both_busy_k%0d", k), busy, 1'b0);
      check($sformatf("both_done_k%0d", k), done, 1'b0);
    end

    // clear_req held three edges
    clear_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) clear_req = 1'b0;
      tick();
      check($sformatf("held_clear_k%0d", k), clear, k <= 3);
      check($sformatf("held_busy_k%0d", k), busy, k <= 3);
    end

    // reset at E0+20 of a decimal print
    value = 32'd987654; dec_mode = 1'b1; term_char = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_append", append_char, 8'h00);
    check("midrst_clear", clear, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_print(32'd1234, 1'b1, 8'h00, 0);

    // reset while a hex digit is on the output
    value = 32'hDEAD_BEEF; dec_mode = 1'b0; term_char = 8'h20; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("hex_pre_rst", append_char, 8'h41);
    #2 rst_n = 1'b0;
    #1;
    check("hexrst_append", append_char, 8'h00);
    check("hexrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_print(32'h0000_1F00, 1'b0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
